// File: rtl/conv_mac_array.sv
// Multi-channel multiply-accumulate engine for window convolution.
// Emits per-channel saturated sums and a saturated gradient magnitude.
module conv_mac_array #(
    parameter int PIX_W    = 8,
    parameter int COEF_W   = 8,
    parameter int TAPS     = 9,
    parameter int CHANNELS = 2,
    parameter int ACC_W    = 24,
    parameter int OUT_W    = 9,
    parameter int MAG_W    = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [PIX_W-1:0]             in_pixel,
    input  logic [CHANNELS*COEF_W-1:0]   in_coef,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [CHANNELS*OUT_W-1:0]    out_result,
    output logic [CHANNELS-1:0]          out_sat,
    output logic [MAG_W-1:0]             out_mag,
    output logic                         busy
);

    localparam int CNT_W = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int SUM_W = ACC_W + $clog2(CHANNELS) + 1;
    localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(TAPS - 1);
    localparam logic signed [ACC_W-1:0] RES_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] RES_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
    localparam logic [SUM_W-1:0] MAG_MAX = {{(SUM_W-MAG_W){1'b0}}, {MAG_W{1'b1}}};

    typedef enum logic [0:0] {ACCUM = 1'b0, HOLD = 1'b1} state_t;

    state_t                  state;
    logic [CNT_W-1:0]        tap_cnt;
    logic signed [ACC_W-1:0] acc      [CHANNELS];
    logic signed [ACC_W-1:0] pix_ext;
    logic signed [ACC_W-1:0] coef_ext [CHANNELS];
    logic signed [ACC_W-1:0] sum      [CHANNELS];
    logic        [ACC_W-1:0] abs_val  [CHANNELS];
    logic [CHANNELS*OUT_W-1:0] res_next;
    logic [CHANNELS-1:0]     sat_next;
    logic [SUM_W-1:0]        mag_sum;
    logic [MAG_W-1:0]        mag_next;

    // Running sums including the current beat, plus clamped results taken on the last beat.
    always_comb begin
        pix_ext  = {{(ACC_W-PIX_W){1'b0}}, in_pixel};
        res_next = '0;
        sat_next = '0;
        mag_sum  = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            coef_ext[c] = {{(ACC_W-COEF_W){in_coef[c*COEF_W+COEF_W-1]}}, in_coef[c*COEF_W +: COEF_W]};
            sum[c]      = acc[c] + pix_ext * coef_ext[c];
            if (sum[c] > RES_MAX) begin
                res_next[c*OUT_W +: OUT_W] = RES_MAX[OUT_W-1:0];
                sat_next[c]                = 1'b1;
            end else if (sum[c] < RES_MIN) begin
                res_next[c*OUT_W +: OUT_W] = RES_MIN[OUT_W-1:0];
                sat_next[c]                = 1'b1;
            end else begin
                res_next[c*OUT_W +: OUT_W] = sum[c][OUT_W-1:0];
                sat_next[c]                = 1'b0;
            end
            // Magnitude uses the unclamped sums; the most negative ACC_W value cannot occur.
            if (sum[c] < $signed({ACC_W{1'b0}})) begin
                abs_val[c] = -sum[c];
            end else begin
                abs_val[c] = sum[c];
            end
            mag_sum = mag_sum + {{(SUM_W-ACC_W){1'b0}}, abs_val[c]};
        end
        if (mag_sum > MAG_MAX) begin
            mag_next = MAG_MAX[MAG_W-1:0];
        end else begin
            mag_next = mag_sum[MAG_W-1:0];
        end
    end

    // Window sequencing: accumulate TAPS beats, then hold the result until it is taken.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ACCUM;
            tap_cnt    <= '0;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_sat    <= '0;
            out_mag    <= '0;
            busy       <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) begin
                acc[c] <= '0;
            end
        end else if (clear) begin
            state     <= ACCUM;
            tap_cnt   <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) begin
                acc[c] <= '0;
            end
        end else begin
            case (state)
                ACCUM: begin
                    if (in_valid) begin
                        if (tap_cnt == LAST_TAP) begin
                            out_result <= res_next;
                            out_sat    <= sat_next;
                            out_mag    <= mag_next;
                            out_valid  <= 1'b1;
                            in_ready   <= 1'b0;
                            state      <= HOLD;
                            tap_cnt    <= '0;
                            busy       <= 1'b0;
                            for (int c = 0; c < CHANNELS; c++) begin
                                acc[c] <= '0;
                            end
                        end else begin
                            tap_cnt <= tap_cnt + CNT_W'(1);
                            busy    <= 1'b1;
                            for (int c = 0; c < CHANNELS; c++) begin
                                acc[c] <= sum[c];
                            end
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ACCUM;
                    end
                end
                default: begin
                    state     <= ACCUM;
                    tap_cnt   <= '0;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_mac_array.sv
// Self-checking bench for conv_mac_array: Sobel vector table, corner sequences
// and randomized windows against an arithmetic reference model.
module tb_conv_mac_array;

    localparam int TAPS = 9;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_pixel = 8'd0;
    logic [15:0] in_coef = 16'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [17:0] out_result;
    logic [1:0]  out_sat;
    logic [7:0]  out_mag;
    logic        busy;

    always #5 clock = ~clock;

    conv_mac_array dut (
        .clock(clock), .reset(reset), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel), .in_coef(in_coef),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_sat(out_sat), .out_mag(out_mag), .busy(busy)
    );

    typedef struct packed {
        logic [8:0][7:0]    pix;
        logic signed [15:0] e0;
        logic signed [15:0] e1;
        logic [1:0]         sat;
        logic [7:0]         mag;
    } vec_t;

    vec_t vecs [4];
    int gx [9] = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
    int gy [9] = '{-1, -2, -1, 0, 0, 0, 1, 2, 1};
    int mp [9];
    int mc0 [9];
    int mc1 [9];
    int passed = 0;
    int total = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic drive_beat(input int i);
        in_valid = 1'b1;
        in_pixel = 8'(mp[i]);
        in_coef  = {8'(mc1[i]), 8'(mc0[i])};
    endtask

    // Feed one window; the result must not be visible before the last beat is taken.
    task automatic feed(input bit gaps);
        int b = 0;
        for (int k = 0; k < 200 && b < TAPS; k++) begin
            @(negedge clock);
            if (gaps && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
            end else begin
                if (b == TAPS - 1) chk("no_early_valid", int'(out_valid), 0);
                drive_beat(b);
                b++;
            end
        end
        chk("feed_done", b, TAPS);
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic check_out(input int e0, input int e1, input int sat, input int mag);
        chk("out_valid", int'(out_valid), 1);
        chk("in_ready_hold", int'(in_ready), 0);
        chk("busy_hold", int'(busy), 0);
        chk("ch0", int'($signed(out_result[8:0])), e0);
        chk("ch1", int'($signed(out_result[17:9])), e1);
        chk("sat", int'(out_sat), sat);
        chk("mag", int'(out_mag), mag);
    endtask

    task automatic release_out(input int hold);
        logic [17:0] r;
        logic [1:0]  s;
        logic [7:0]  m;
        r = out_result; s = out_sat; m = out_mag;
        for (int h = 0; h < hold; h++) begin
            @(negedge clock);
            chk("stall_valid", int'(out_valid), 1);
            chk("stall_ready", int'(in_ready), 0);
            chk("stall_result", int'(out_result), int'(r));
            chk("stall_sat_mag", int'({out_sat, out_mag}), int'({s, m}));
        end
        out_ready = 1'b1;
        @(negedge clock);
        chk("pop_valid", int'(out_valid), 0);
        chk("pop_ready", int'(in_ready), 1);
        out_ready = 1'b0;
    endtask

    function automatic int clamp(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic model(output int e0, output int e1, output int sat, output int mag);
        int s0 = 0;
        int s1 = 0;
        for (int i = 0; i < TAPS; i++) begin
            s0 += mp[i] * mc0[i];
            s1 += mp[i] * mc1[i];
        end
        e0  = clamp(s0, -256, 255);
        e1  = clamp(s1, -256, 255);
        sat = ((e1 != s1) ? 2 : 0) + ((e0 != s0) ? 1 : 0);
        mag = clamp(iabs(s0) + iabs(s1), 0, 255);
    endtask

    initial begin
        int e0, e1, es, em;

        for (int i = 0; i < 9; i++) begin
            vecs[0].pix[i] = (i % 3 == 2) ? 8'd20 : 8'd10;
            vecs[1].pix[i] = (i % 3 == 0) ? 8'd20 : 8'd10;
            vecs[2].pix[i] = (i % 3 == 2) ? 8'd255 : 8'd0;
            vecs[3].pix[i] = (i % 3 == 0) ? 8'd255 : 8'd0;
        end
        vecs[0].e0 = 16'sd40;   vecs[0].e1 = 16'sd0; vecs[0].sat = 2'b00; vecs[0].mag = 8'd40;
        vecs[1].e0 = -16'sd40;  vecs[1].e1 = 16'sd0; vecs[1].sat = 2'b00; vecs[1].mag = 8'd40;
        vecs[2].e0 = 16'sd255;  vecs[2].e1 = 16'sd0; vecs[2].sat = 2'b01; vecs[2].mag = 8'd255;
        vecs[3].e0 = -16'sd256; vecs[3].e1 = 16'sd0; vecs[3].sat = 2'b01; vecs[3].mag = 8'd255;
        for (int i = 0; i < 9; i++) begin
            mc0[i] = gx[i];
            mc1[i] = gy[i];
        end

        repeat (2) @(negedge clock);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_outputs", int'({out_result, out_sat, out_mag}), 0);
        reset = 1'b0;

        // Sobel table; the first entry also exercises a 5-cycle stall.
        for (int v = 0; v < 4; v++) begin
            for (int i = 0; i < 9; i++) mp[i] = int'(vecs[v].pix[i]);
            feed(1'b0);
            check_out(int'(vecs[v].e0), int'(vecs[v].e1), int'(vecs[v].sat), int'(vecs[v].mag));
            release_out((v == 0) ? 5 : 0);
        end

        // Abort after four beats; the discarded beat must not leak into the next window.
        for (int i = 0; i < 9; i++) mp[i] = int'(vecs[0].pix[i]);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            drive_beat(i);
        end
        @(negedge clock);
        chk("busy_mid", int'(busy), 1);
        clear = 1'b1;
        drive_beat(4);
        @(negedge clock);
        clear = 1'b0;
        in_valid = 1'b0;
        chk("clear_busy", int'(busy), 0);
        chk("clear_valid", int'(out_valid), 0);
        chk("clear_ready", int'(in_ready), 1);
        feed(1'b0);
        check_out(40, 0, 0, 40);
        release_out(0);

        // Randomized windows with input gaps and output stalls.
        for (int w = 0; w < 20; w++) begin
            for (int i = 0; i < 9; i++) begin
                mp[i]  = int'($urandom_range(0, 255));
                mc0[i] = int'($urandom_range(0, 255)) - 128;
                mc1[i] = (w < 4) ? int'($urandom_range(0, 2)) - 1 : int'($urandom_range(0, 255)) - 128;
            end
            model(e0, e1, es, em);
            feed(1'b1);
            check_out(e0, e1, es, em);
            release_out(int'($urandom_range(0, 2)));
        end

        // Reset while holding a result drops everything asynchronously.
        for (int i = 0; i < 9; i++) begin
            mp[i] = int'(vecs[2].pix[i]);
            mc0[i] = gx[i];
            mc1[i] = gy[i];
        end
        feed(1'b0);
        check_out(255, 0, 1, 255);
        #2 reset = 1'b1;
        #1;
        chk("areset_valid", int'(out_valid), 0);
        chk("areset_ready", int'(in_ready), 1);
        chk("areset_mag", int'(out_mag), 0);
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 9; i++) mp[i] = int'(vecs[1].pix[i]);
        feed(1'b0);
        check_out(-40, 0, 0, 40);
        release_out(0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/conv_mac_array.md
Name: conv_mac_array

Overview:
Parametrised multi-channel multiply-accumulate engine for window convolution, such as a Sobel Gx/Gy pair. It runs one shared unsigned pixel stream against CHANNELS independent signed coefficient streams and counts TAPS beats per window. For each window it emits a saturated signed result per channel plus a saturated gradient magnitude, with valid/ready handshakes on both sides. It sits between the window/line-buffer fetch logic and the edge-threshold stage.

Parameters:
PIX_W, 8, pixel width (unsigned)
COEF_W, 8, coefficient width per channel (signed two's complement)
TAPS, 9, beats accumulated per window (>=1)
CHANNELS, 2, parallel accumulator channels (>=1)
ACC_W, 24, accumulator width; must be >= PIX_W+COEF_W+clog2(TAPS)+1
OUT_W, 9, signed per-channel result width
MAG_W, 8, unsigned magnitude width

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
clear  in  1  synchronous abort of the current window
in_valid  in  1  beat offered
in_ready  out  1  beat can be accepted
in_pixel  in  PIX_W  unsigned pixel
in_coef  in  CHANNELS*COEF_W  signed coefficients; channel c at bits [c*COEF_W +: COEF_W]
out_valid  out  1  window result available
out_ready  in  1  downstream accepts result
out_result  out  CHANNELS*OUT_W  saturated signed sums, same packing as in_coef
out_sat  out  CHANNELS  per-channel saturation occurred
out_mag  out  MAG_W  saturated sum of per-channel absolute values
busy  out  1  window partially accumulated (tap count != 0)

Behaviour:
- Single clock domain. Reset is asynchronous and active-high. Port names are clock and reset.
- Reset values: all outputs 0 except in_ready=1. Internally: state ACCUM, tap_cnt=0, accumulators 0.
- States:
  - ACCUM: in_ready=1.
  - HOLD: in_ready=0, out_valid=1.
- Beat acceptance: in_valid & in_ready on a rising edge.
  - Each accepted beat: acc[c] += zero_ext(in_pixel) * signed(in_coef[c]) for every c, full ACC_W signed arithmetic.
  - Each accepted beat increments tap_cnt.
- Window completion: on the accepted beat where tap_cnt==TAPS-1, on that same edge:
  - register out_result, out_sat and out_mag from the final sums, including that beat's products;
  - set out_valid=1 and go to HOLD;
  - reset tap_cnt and all accumulators to 0.
- Latency: out_valid is high in the cycle after the last beat is accepted.
- Throughput: at best TAPS+1 cycles per window.
- HOLD exit: out_valid & out_ready on an edge → out_valid=0, state ACCUM, in_ready=1 from the next cycle.
- HOLD stability: while out_valid=1 and out_ready=0, all out_* remain stable.
- Per-channel saturation: final sum s clamps to [-2^(OUT_W-1), 2^(OUT_W-1)-1] (OUT_W=9 gives -256..255). out_sat[c]=1 iff clamping occurred.
- Magnitude:
  - sum of |s_c| over channels, using unsaturated sums, computed in ACC_W+clog2(CHANNELS)+1 bits;
  - clamped to 2^MAG_W-1 (255 for the defaults).
- clear:
  - synchronous, priority over in_valid and out_ready;
  - zeroes tap_cnt and accumulators, drops out_valid, returns to ACCUM;
  - any beat presented in the same cycle is discarded.
- Reset mid-window or mid-HOLD discards everything immediately, with no output pulse.
- busy=1 iff tap_cnt!=0.
- Accumulators never wrap under the ACC_W constraint. Behaviour with a smaller ACC_W is undefined.
- TAPS=1 is legal: every accepted beat completes a window.

Test Plan:
- Reset then Sobel Gx coefficients [-1,0,1,-2,0,2,-1,0,1] on ch0 and Gy [-1,-2,-1,0,0,0,1,2,1] on ch1, pixels [10,10,20,10,10,20,10,10,20], in_valid held high → out_valid exactly 1 cycle after the 9th beat; ch0=40, ch1=0, out_mag=40, out_sat=00.
- Same coefficients, pixels [20,10,10,20,10,10,20,10,10] → ch0=-40, out_mag=40.
- Pixels [0,0,255]x3 → ch0 raw 1020, clamped to 255, out_sat[0]=1; ch1=0; out_mag=255.
- Pixels [255,0,0]x3 → ch0 clamped to -256, out_sat[0]=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid → in_ready=0 and outputs stable throughout; out_ready=1 → out_valid drops next edge; the next window is accepted normally.
- Pulse clear after 4 beats (busy=1) → busy=0, no output. A following clean 9-beat window gives exactly the first scenario's values.
- Separately assert reset during HOLD → out_valid drops asynchronously and in_ready=1.
